// File: rtl/line_draw_pkg.sv
// Shared types for the line-draw scheduler: FSM state encoding, coordinate width
// and a point record used by the draw path.
package line_draw_pkg;

  localparam int COORD_W = 11;

  typedef enum logic [2:0] {
    IDLE,
    START,
    LOAD,
    DRAW,
    FIN
  } lds_state_e;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } point_t;

endpackage

// File: rtl/line_draw_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set request at or after ptr,
// wrapping around. The pointer register lives in the scheduler.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt_onehot,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  int cand;

  // Scan from the farthest candidate back toward ptr so the nearest one wins.
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    cand       = 0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = int'(ptr) + i;
      if (cand >= N) cand = cand - N;
      if (req[cand]) begin
        any     = 1'b1;
        gnt_idx = IW'(cand);
      end
    end
    if (any) gnt_onehot[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/line_draw_scheduler.sv
// Shares one Bresenham engine among N_REQ round-robin requesters and turns engine
// points into framebuffer writes. Optional DRAW watchdog: define LDS_WATCHDOG_EN.
module line_draw_scheduler #(
  parameter int N_REQ     = 4,
  parameter int COORD_W   = 11,
  parameter int COLOR_W   = 1,
  parameter int WD_CYCLES = 4096
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*COORD_W-1:0]   req_x0,
  input  logic [N_REQ*COORD_W-1:0]   req_y0,
  input  logic [N_REQ*COORD_W-1:0]   req_x1,
  input  logic [N_REQ*COORD_W-1:0]   req_y1,
  input  logic [N_REQ*COLOR_W-1:0]   req_color,
  output logic [N_REQ-1:0]           ack,
  output logic                       busy,
  output logic                       drw_rst,
  output logic [COORD_W-1:0]         drw_x0,
  output logic [COORD_W-1:0]         drw_y0,
  output logic [COORD_W-1:0]         drw_x1,
  output logic [COORD_W-1:0]         drw_y1,
  input  logic [COORD_W-1:0]         drw_x,
  input  logic [COORD_W-1:0]         drw_y,
  input  logic                       drw_done,
  output logic                       pix_we,
  output logic [COORD_W-1:0]         pix_x,
  output logic [COORD_W-1:0]         pix_y,
  output logic [COLOR_W-1:0]         pix_color
`ifdef LDS_WATCHDOG_EN
  ,
  output logic                       wd_abort
`endif
);

  import line_draw_pkg::*;

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  lds_state_e          state_q, state_d;
  logic [IW-1:0]       rr_ptr_q, grant_q, arb_idx;
  logic [N_REQ-1:0]    arb_onehot;
  logic                arb_any;
  logic [COORD_W-1:0]  x0_q, y0_q, x1_q, y1_q;
  logic [COLOR_W-1:0]  color_q;
  logic                wd_hit;

  rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
    .req        (req),
    .ptr        (rr_ptr_q),
    .gnt_onehot (arb_onehot),
    .gnt_idx    (arb_idx),
    .any        (arb_any)
  );

  // The owner's line is captured once at grant so later requester changes are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      x0_q     <= '0;
      y0_q     <= '0;
      x1_q     <= '0;
      y1_q     <= '0;
      color_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && arb_any) begin
        grant_q <= arb_idx;
        x0_q    <= req_x0[int'(arb_idx)*COORD_W +: COORD_W];
        y0_q    <= req_y0[int'(arb_idx)*COORD_W +: COORD_W];
        x1_q    <= req_x1[int'(arb_idx)*COORD_W +: COORD_W];
        y1_q    <= req_y1[int'(arb_idx)*COORD_W +: COORD_W];
        color_q <= req_color[int'(arb_idx)*COLOR_W +: COLOR_W];
      end
      if (state_q == FIN)
        rr_ptr_q <= (grant_q == IW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
    end
  end

`ifdef LDS_WATCHDOG_EN
  localparam int WDW = $clog2(WD_CYCLES + 1);

  logic [WDW-1:0] wd_cnt_q;
  logic           abort_q;

  assign wd_hit = (wd_cnt_q == WDW'(WD_CYCLES - 1));

  // A coincident drw_done on the final allowed cycle counts as a normal finish.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt_q <= '0;
      abort_q  <= 1'b0;
    end else begin
      wd_cnt_q <= (state_q == DRAW) ? wd_cnt_q + 1'b1 : '0;
      if (state_q == DRAW) abort_q <= wd_hit && !drw_done;
    end
  end

  assign wd_abort = (state_q == FIN) && abort_q;
`else
  assign wd_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    drw_rst = 1'b1;
    pix_we  = 1'b0;
    ack     = '0;
    case (state_q)
      IDLE:  if (arb_any) state_d = START;
      START: state_d = LOAD;
      LOAD: begin
        drw_rst = 1'b0;
        state_d = DRAW;
      end
      DRAW: begin
        drw_rst = 1'b0;
        pix_we  = 1'b1;
        if (drw_done || wd_hit) state_d = FIN;
      end
      FIN: begin
        ack[grant_q] = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign drw_x0    = x0_q;
  assign drw_y0    = y0_q;
  assign drw_x1    = x1_q;
  assign drw_y1    = y1_q;
  assign pix_x     = drw_x;
  assign pix_y     = drw_y;
  assign pix_color = color_q;

endmodule

// File: tb/tb_line_draw_scheduler.sv
// Directed bench for line_draw_scheduler with a behavioural Bresenham engine;
// the watchdog scenario is built only when LDS_WATCHDOG_EN is defined.
module tb_line_draw_scheduler;

  localparam int N  = 4;
  localparam int CW = 11;
  localparam int KW = 1;
`ifdef LDS_WATCHDOG_EN
  localparam int WD = 8;
`else
  localparam int WD = 4096;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*CW-1:0] req_x0, req_y0, req_x1, req_y1;
  logic [N*KW-1:0] req_color;
  logic [N-1:0]    ack;
  logic            busy, drw_rst, drw_done, pix_we, wd_abort;
  logic [CW-1:0]   drw_x0, drw_y0, drw_x1, drw_y1, pix_x, pix_y;
  logic [KW-1:0]   pix_color;

  logic [CW-1:0] ex = '0, ey = '0, ex1 = '0, ey1 = '0;
  int            err_e = 0, edx = 0, edy = 0, esx = 0, esy = 0;
  bit            loaded = 1'b0;
  bit            no_done = 1'b0;

  int errors = 0;
  int checks = 0;
  int px[$], py[$], pc[$], ack_order[$];
  int first_pix, last_pix, ack_at, wd_pulses, wd_with_ack, bad_ack;
  bit timed_out;

  always #5 clk = ~clk;

  line_draw_scheduler #(.N_REQ(N), .COORD_W(CW), .COLOR_W(KW), .WD_CYCLES(WD)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_x0    (req_x0),
    .req_y0    (req_y0),
    .req_x1    (req_x1),
    .req_y1    (req_y1),
    .req_color (req_color),
    .ack       (ack),
    .busy      (busy),
    .drw_rst   (drw_rst),
    .drw_x0    (drw_x0),
    .drw_y0    (drw_y0),
    .drw_x1    (drw_x1),
    .drw_y1    (drw_y1),
    .drw_x     (ex),
    .drw_y     (ey),
    .drw_done  (drw_done),
    .pix_we    (pix_we),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_color (pix_color)
`ifdef LDS_WATCHDOG_EN
    ,
    .wd_abort  (wd_abort)
`endif
  );

`ifndef LDS_WATCHDOG_EN
  assign wd_abort = 1'b0;
`endif

  // Engine model: loads on the first cycle out of reset, then steps once per cycle.
  always @(posedge clk) begin
    int e2, dx, dy, ne;
    if (drw_rst) begin
      loaded <= 1'b0;
    end else if (!loaded) begin
      dx = (drw_x1 >= drw_x0) ? int'(drw_x1) - int'(drw_x0) : int'(drw_x0) - int'(drw_x1);
      dy = (drw_y1 >= drw_y0) ? int'(drw_y0) - int'(drw_y1) : int'(drw_y1) - int'(drw_y0);
      loaded <= 1'b1;
      ex  <= drw_x0;
      ey  <= drw_y0;
      ex1 <= drw_x1;
      ey1 <= drw_y1;
      edx <= dx;
      edy <= dy;
      esx <= (drw_x0 < drw_x1) ? 1 : -1;
      esy <= (drw_y0 < drw_y1) ? 1 : -1;
      err_e <= dx + dy;
    end else if (no_done || ex != ex1 || ey != ey1) begin
      e2 = 2 * err_e;
      ne = err_e;
      if (e2 >= edy) begin
        ne = ne + edy;
        ex <= ex + CW'(esx);
      end
      if (e2 <= edx) begin
        ne = ne + edx;
        ey <= ey + CW'(esy);
      end
      err_e <= ne;
    end
  end

  assign drw_done = loaded && !no_done && (ex == ex1) && (ey == ey1);

  task automatic set_line(input int r, input int x0, input int y0, input int x1, input int y1,
                          input int c);
    req_x0[r*CW +: CW]    = CW'(x0);
    req_y0[r*CW +: CW]    = CW'(y0);
    req_x1[r*CW +: CW]    = CW'(x1);
    req_y1[r*CW +: CW]    = CW'(y1);
    req_color[r*KW +: KW] = KW'(c);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Runs the clients for up to budget cycles, logging pixels and acks; each requester
  // drops its req on its own ack. hook_at injects extra reqs and/or scrambles inputs.
  task automatic collect(input int want, input int budget, input int hook_at,
                         input logic [N-1:0] hook_req, input bit scramble);
    px.delete(); py.delete(); pc.delete(); ack_order.delete();
    first_pix = -1; last_pix = -1; ack_at = -1;
    wd_pulses = 0; wd_with_ack = 0; bad_ack = 0; timed_out = 1'b0;
    for (int s = 1; s <= budget && ack_order.size() < want; s++) begin
      @(negedge clk);
      if (pix_we) begin
        px.push_back(int'(pix_x));
        py.push_back(int'(pix_y));
        pc.push_back(int'(pix_color));
        if (first_pix < 0) first_pix = s;
        last_pix = s;
      end
      if (wd_abort) begin
        wd_pulses++;
        if (ack != '0) wd_with_ack++;
      end
      if (ack != '0) begin
        if (!$onehot(ack)) bad_ack++;
        for (int i = 0; i < N; i++)
          if (ack[i]) begin
            ack_order.push_back(i);
            req[i] = 1'b0;
          end
        ack_at = s;
      end
      if (s == hook_at) begin
        req = req | hook_req;
        if (scramble) begin
          req_x0    = '1;
          req_y0    = '1;
          req_x1    = '0;
          req_y1    = '0;
          req_color = ~req_color;
        end
      end
    end
    if (ack_order.size() < want) timed_out = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (ack !== 4'b0000) begin errors++; $display("[TB] FAIL reset_ack: got %b expected 0000", ack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (drw_rst !== 1'b1) begin errors++; $display("[TB] FAIL reset_drw_rst: got %b expected 1", drw_rst); end
    checks++; if (pix_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_pix_we: got %b expected 0", pix_we); end
    checks++; if ({drw_x0, drw_y0, drw_x1, drw_y1} !== 44'h0) begin
      errors++; $display("[TB] FAIL reset_endpoints: got %h expected 0", {drw_x0, drw_y0, drw_x1, drw_y1});
    end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_single_line();
    set_line(0, 3, 2, 7, 2, 1);
    req = 4'b0001;
    collect(1, 60, 0, 4'b0000, 1'b0);
    checks++; if (timed_out !== 1'b0) begin errors++; $display("[TB] FAIL single_timeout: got %0d acks expected 1", ack_order.size()); end
    checks++; if (px.size() !== 5) begin errors++; $display("[TB] FAIL single_npix: got %0d expected 5", px.size()); end
    for (int i = 0; i < px.size() && i < 5; i++) begin
      checks++;
      if (px[i] !== 3 + i || py[i] !== 2 || pc[i] !== 1) begin
        errors++; $display("[TB] FAIL single_pix%0d: got (%0d,%0d) c%0d expected (%0d,2) c1", i, px[i], py[i], pc[i], 3 + i);
      end
    end
    checks++; if (first_pix !== 3) begin errors++; $display("[TB] FAIL single_latency: got %0d expected 3", first_pix); end
    checks++; if (ack_at !== 8) begin errors++; $display("[TB] FAIL single_ack_cycle: got %0d expected 8", ack_at); end
    checks++; if (ack_order.size() < 1 || ack_order[0] !== 0) begin errors++; $display("[TB] FAIL single_ack_owner: got %0d acks expected owner 0", ack_order.size()); end
    checks++; if (wd_pulses !== 0) begin errors++; $display("[TB] FAIL single_wd_abort: got %0d expected 0", wd_pulses); end
    @(negedge clk);
    checks++; if (ack !== 4'b0000) begin errors++; $display("[TB] FAIL single_ack_pulse: got %b expected 0000", ack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL single_busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_round_robin();
    int exp_a[4];
    int exp_b[3];
    exp_a = '{0, 1, 2, 3};
    exp_b = '{1, 2, 0};
    pulse_reset();
    set_line(0, 0, 0, 2, 0, 1);
    set_line(1, 0, 1, 0, 3, 0);
    set_line(2, 5, 5, 6, 6, 1);
    set_line(3, 9, 9, 9, 9, 0);
    req = 4'b1111;
    collect(4, 200, 0, 4'b0000, 1'b0);
    checks++; if (timed_out !== 1'b0 || bad_ack !== 0) begin errors++; $display("[TB] FAIL rr_acks: got %0d acks %0d bad expected 4 clean", ack_order.size(), bad_ack); end
    for (int i = 0; i < 4 && i < ack_order.size(); i++) begin
      checks++; if (ack_order[i] !== exp_a[i]) begin errors++; $display("[TB] FAIL rr_order%0d: got %0d expected %0d", i, ack_order[i], exp_a[i]); end
    end
    checks++; if (px.size() !== 9) begin errors++; $display("[TB] FAIL rr_npix: got %0d expected 9", px.size()); end
    req = 4'b0010;
    collect(3, 200, 4, 4'b0101, 1'b0);
    checks++; if (timed_out !== 1'b0) begin errors++; $display("[TB] FAIL rr2_acks: got %0d expected 3", ack_order.size()); end
    for (int i = 0; i < 3 && i < ack_order.size(); i++) begin
      checks++; if (ack_order[i] !== exp_b[i]) begin errors++; $display("[TB] FAIL rr2_order%0d: got %0d expected %0d", i, ack_order[i], exp_b[i]); end
    end
  endtask

  task automatic test_shapes();
    set_line(1, 3, 2, 3, 6, 1);
    req = 4'b0010;
    collect(1, 60, 5, 4'b0000, 1'b1);
    checks++; if (px.size() !== 5 || timed_out) begin errors++; $display("[TB] FAIL vert_npix: got %0d expected 5", px.size()); end
    for (int i = 0; i < px.size() && i < 5; i++) begin
      checks++;
      if (px[i] !== 3 || py[i] !== 2 + i || pc[i] !== 1) begin
        errors++; $display("[TB] FAIL vert_pix%0d: got (%0d,%0d) c%0d expected (3,%0d) c1", i, px[i], py[i], pc[i], 2 + i);
      end
    end
    checks++; if (drw_x0 !== 11'd3 || drw_y1 !== 11'd6) begin errors++; $display("[TB] FAIL vert_latched: got x0=%0d y1=%0d expected 3 6", drw_x0, drw_y1); end
    set_line(2, 1, 1, 5, 5, 0);
    req = 4'b0100;
    collect(1, 60, 5, 4'b0000, 1'b1);
    checks++; if (px.size() !== 5 || timed_out) begin errors++; $display("[TB] FAIL diag_npix: got %0d expected 5", px.size()); end
    for (int i = 0; i < px.size() && i < 5; i++) begin
      checks++;
      if (px[i] !== 1 + i || py[i] !== 1 + i || pc[i] !== 0) begin
        errors++; $display("[TB] FAIL diag_pix%0d: got (%0d,%0d) c%0d expected (%0d,%0d) c0", i, px[i], py[i], pc[i], 1 + i, 1 + i);
      end
    end
    checks++; if (ack_order.size() < 1 || ack_order[0] !== 2) begin errors++; $display("[TB] FAIL diag_owner: got %0d acks expected owner 2", ack_order.size()); end
  endtask

  task automatic test_reset_mid_draw();
    set_line(3, 1, 1, 12, 5, 1);
    req = 4'b1000;
    repeat (5) @(negedge clk);
    checks++; if (pix_we !== 1'b1) begin errors++; $display("[TB] FAIL rmd_drawing: got %b expected 1", pix_we); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (pix_we !== 1'b0) begin errors++; $display("[TB] FAIL rmd_pix_we: got %b expected 0", pix_we); end
    checks++; if (ack !== 4'b0000) begin errors++; $display("[TB] FAIL rmd_ack: got %b expected 0000", ack); end
    checks++; if (drw_rst !== 1'b1) begin errors++; $display("[TB] FAIL rmd_drw_rst: got %b expected 1", drw_rst); end
    reset = 1'b0;
    set_line(0, 0, 0, 1, 0, 1);
    req = 4'b1001;
    collect(1, 60, 0, 4'b0000, 1'b0);
    checks++; if (ack_order.size() < 1 || ack_order[0] !== 0) begin errors++; $display("[TB] FAIL rmd_regrant: got %0d acks expected owner 0", ack_order.size()); end
    collect(1, 80, 0, 4'b0000, 1'b0);
    checks++; if (ack_order.size() < 1 || ack_order[0] !== 3) begin errors++; $display("[TB] FAIL rmd_second: got %0d acks expected owner 3", ack_order.size()); end
  endtask

  task automatic test_zero_length();
    set_line(0, 4, 4, 4, 4, 1);
    req = 4'b0001;
    collect(1, 40, 0, 4'b0000, 1'b0);
    checks++; if (timed_out !== 1'b0) begin errors++; $display("[TB] FAIL zero_timeout: got %0d acks expected 1", ack_order.size()); end
    checks++; if (px.size() < 1 || px[0] !== 4 || py[0] !== 4) begin errors++; $display("[TB] FAIL zero_pixel: got %0d pixels expected (4,4)", px.size()); end
    checks++; if (ack_order.size() < 1 || ack_order[0] !== 0) begin errors++; $display("[TB] FAIL zero_owner: got %0d acks expected owner 0", ack_order.size()); end
  endtask

`ifdef LDS_WATCHDOG_EN
  task automatic test_watchdog();
    no_done = 1'b1;
    set_line(0, 1, 1, 5, 5, 1);
    req = 4'b0001;
    collect(1, 100, 0, 4'b0000, 1'b0);
    checks++; if (timed_out !== 1'b0) begin errors++; $display("[TB] FAIL wd_timeout: got %0d acks expected 1", ack_order.size()); end
    checks++; if (px.size() !== 8) begin errors++; $display("[TB] FAIL wd_npix: got %0d expected 8", px.size()); end
    checks++; if (wd_pulses !== 1 || wd_with_ack !== 1) begin errors++; $display("[TB] FAIL wd_abort: got %0d pulses %0d with ack expected 1 1", wd_pulses, wd_with_ack); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || wd_abort !== 1'b0) begin errors++; $display("[TB] FAIL wd_idle: got busy=%b wd=%b expected 0 0", busy, wd_abort); end
    no_done = 1'b0;
  endtask
`endif

  initial begin
    reset     = 1'b1;
    req       = '0;
    req_x0    = '0;
    req_y0    = '0;
    req_x1    = '0;
    req_y1    = '0;
    req_color = '0;
    test_reset();
    test_single_line();
    test_round_robin();
    test_shapes();
    test_reset_mid_draw();
    test_zero_length();
`ifdef LDS_WATCHDOG_EN
    test_watchdog();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
